// File: rtl/bslu_seq_pkg.sv
// Shared constants for the bit-serial BSLU sequencer: command opcodes,
// BSLU one-hot op/register encodings and the sequencer state encoding.
package bslu_seq_pkg;

  // Command opcodes; 5..7 are rejected as illegal.
  localparam logic [2:0] CMD_COPY = 3'd0;
  localparam logic [2:0] CMD_NOT  = 3'd1;
  localparam logic [2:0] CMD_AND  = 3'd2;
  localparam logic [2:0] CMD_OR   = 3'd3;
  localparam logic [2:0] CMD_XOR  = 3'd4;

  // One-hot BSLU operation bus.
  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h01;
  localparam logic [7:0] OP_SET  = 8'h02;
  localparam logic [7:0] OP_SETV = 8'h04;
  localparam logic [7:0] OP_NOT  = 8'h08;
  localparam logic [7:0] OP_AND  = 8'h10;
  localparam logic [7:0] OP_OR   = 8'h20;
  localparam logic [7:0] OP_XOR  = 8'h40;
  localparam logic [7:0] OP_SEL  = 8'h80;

  // One-hot BSLU register selects.
  localparam logic [2:0] REG_NONE = 3'b000;
  localparam logic [2:0] REG_SA   = 3'b001;
  localparam logic [2:0] REG_CR   = 3'b010;
  localparam logic [2:0] REG_PR   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_MV   = 3'd2,
    ST_RD2  = 3'd3,
    ST_ALU  = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return (op <= CMD_XOR);
  endfunction

  // BSLU operation issued in the ALU step for a given command.
  function automatic logic [7:0] alu_op(input logic [2:0] op);
    case (op)
      CMD_NOT: return OP_NOT;
      CMD_AND: return OP_AND;
      CMD_OR:  return OP_OR;
      CMD_XOR: return OP_XOR;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bslu_seq_memif.sv
// Row-port front end shared by the RD1, RD2 and WR states. The request is
// held for as long as the owning state is active (the state only advances
// on fin), and the address is forced to zero whenever no access is pending
// so the port never shows a stale row. An ack without a request is ignored.
module bslu_seq_memif #(
  parameter int AW = 16
) (
  input  logic          access,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          fin
);

  // Qualify request, direction and address with the access window.
  always_comb begin
    mem_req  = access;
    mem_we   = access & we;
    mem_addr = access ? addr : '0;
    fin      = access & mem_ack;
  end

endmodule

// File: rtl/bslu_seq.sv
// Bit-serial micro-op sequencer: expands one vertical bitwise command into
// per-bit row reads, BSLU register ops and row write-backs.
// Optional macro BSLU_SEQ_PERF_EN adds perf_cycles / perf_stall counters.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid & cmd_ready are both high. cmd_ready is high only in IDLE and
// does not depend on cmd_valid; all cmd_* fields are captured at transfer.
module bslu_seq
  import bslu_seq_pkg::*;
#(
  parameter int AW  = 16,
  parameter int NBW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [AW-1:0]  cmd_src1,
  input  logic [AW-1:0]  cmd_src2,
  input  logic [AW-1:0]  cmd_dst,
  input  logic [NBW-1:0] cmd_nbits,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  input  logic           mem_ack,
  output logic [7:0]     bslu_op,
  output logic [2:0]     bslu_rs1,
  output logic [2:0]     bslu_rs2,
  output logic [2:0]     bslu_rd,
  output logic           busy,
  output logic           done,
  output logic           err
`ifdef BSLU_SEQ_PERF_EN
  ,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stall
`endif
);

  state_t         state, state_d;
  logic [NBW-1:0] bit_idx, bit_d;
  logic [2:0]     op_q;
  logic [AW-1:0]  src1_q, src2_q, dst_q;
  logic [NBW-1:0] nbits_q;
  logic           err_q;

  logic           accept;
  logic           acc, acc_we, fin;
  logic [AW-1:0]  acc_addr;
  logic [AW-1:0]  idx_ext;
  logic           last_bit;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign err       = err_q;
  assign idx_ext   = AW'(bit_idx);
  assign last_bit  = ({1'b0, bit_idx} + 1'b1) >= {1'b0, nbits_q};

  bslu_seq_memif #(.AW(AW)) u_memif (
    .access   (acc),
    .we       (acc_we),
    .addr     (acc_addr),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .fin      (fin)
  );

  // State register, bit counter, command capture and the err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      nbits_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_d;
      bit_idx <= bit_d;
      err_q   <= accept & ~is_legal(cmd_op);
      if (accept) begin
        op_q    <= cmd_op;
        src1_q  <= cmd_src1;
        src2_q  <= cmd_src2;
        dst_q   <= cmd_dst;
        nbits_q <= cmd_nbits;
      end
    end
  end

  // Next-state, row-port access and BSLU bus decode per state.
  always_comb begin
    state_d  = state;
    bit_d    = bit_idx;
    acc      = 1'b0;
    acc_we   = 1'b0;
    acc_addr = '0;
    bslu_op  = OP_NONE;
    bslu_rs1 = REG_NONE;
    bslu_rs2 = REG_NONE;
    bslu_rd  = REG_NONE;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          bit_d = '0;
          if (!is_legal(cmd_op))    state_d = ST_IDLE;
          else if (cmd_nbits == '0) state_d = ST_DONE;
          else                      state_d = ST_RD1;
        end
      end
      ST_RD1: begin
        acc      = 1'b1;
        acc_addr = src1_q + idx_ext;
        if (fin) begin
          if (op_q == CMD_COPY)     state_d = ST_WR;
          else if (op_q == CMD_NOT) state_d = ST_ALU;
          else                      state_d = ST_MV;
        end
      end
      ST_MV: begin
        // Park operand A in pr so sa is free for operand B.
        bslu_op  = OP_MOV;
        bslu_rs1 = REG_SA;
        bslu_rd  = REG_PR;
        state_d  = ST_RD2;
      end
      ST_RD2: begin
        acc      = 1'b1;
        acc_addr = src2_q + idx_ext;
        if (fin) state_d = ST_ALU;
      end
      ST_ALU: begin
        bslu_op  = alu_op(op_q);
        bslu_rs1 = REG_SA;
        bslu_rs2 = (op_q == CMD_NOT) ? REG_NONE : REG_PR;
        bslu_rd  = REG_SA;
        state_d  = ST_WR;
      end
      ST_WR: begin
        acc      = 1'b1;
        acc_we   = 1'b1;
        acc_addr = dst_q + idx_ext;
        if (fin) begin
          if (last_bit) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_idx + 1'b1;
            state_d = ST_RD1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BSLU_SEQ_PERF_EN
  // Busy and memory-stall cycle counters for the most recent command.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy)                perf_cycles <= perf_cycles + 32'd1;
      if (mem_req && !mem_ack) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bslu_seq.sv
// Bench for bslu_seq: directed cases plus random commands, checked against a
// per-command expectation of row accesses and BSLU ops built from the
// command semantics.
module tb_bslu_seq;

  localparam int AW  = 16;
  localparam int NBW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [AW-1:0]  cmd_src1, cmd_src2, cmd_dst;
  logic [NBW-1:0] cmd_nbits;
  logic           mem_req, mem_we, mem_ack;
  logic [AW-1:0]  mem_addr;
  logic [7:0]     bslu_op;
  logic [2:0]     bslu_rs1, bslu_rs2, bslu_rd;
  logic           busy, done, err;
`ifdef BSLU_SEQ_PERF_EN
  logic [31:0]    perf_cycles, perf_stall;
`endif

  bslu_seq #(.AW(AW), .NBW(NBW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
    .cmd_dst   (cmd_dst),
    .cmd_nbits (cmd_nbits),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .bslu_op   (bslu_op),
    .bslu_rs1  (bslu_rs1),
    .bslu_rs2  (bslu_rs2),
    .bslu_rd   (bslu_rd),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef BSLU_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stall  (perf_stall)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Expected row accesses {we, addr} and BSLU ops {op, rs1, rs2, rd}.
  logic [16:0] exp_mem_q[$];
  logic [16:0] exp_bslu_q[$];

  int ack_mode = 0;   // 0: ack always high, 1: ack on 3rd req cycle, 2: random
  int exp_hold = 1;   // expected req length in cycles, 0 = unchecked

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder + monitor ----------------
  initial begin
    int          hold;
    bit          prev_pend;
    logic [16:0] prev_acc;
    logic [16:0] e;
    hold      = 0;
    prev_pend = 1'b0;
    prev_acc  = '0;
    mem_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) hold++;
      else         hold = 0;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (hold >= 3);
        default: mem_ack = ($urandom_range(0, 2) == 0);
      endcase
      if (rst) begin
        prev_pend = 1'b0;
        hold      = 0;
      end else begin
        if (mem_req) begin
          if (prev_pend) check("addr_stable", {15'd0, mem_we, mem_addr}, {15'd0, prev_acc});
          if (mem_ack) begin
            check("mem_expected", 32'(exp_mem_q.size() != 0), 32'd1);
            if (exp_mem_q.size() != 0) begin
              e = exp_mem_q.pop_front();
              check("mem_access", {15'd0, mem_we, mem_addr}, {15'd0, e});
            end
            if (exp_hold != 0) check("req_hold_cycles", hold, exp_hold);
            prev_pend = 1'b0;
            hold      = 0;
          end else begin
            prev_pend = 1'b1;
            prev_acc  = {mem_we, mem_addr};
          end
        end else begin
          prev_pend = 1'b0;
        end
        if (bslu_op != 8'h00) begin
          check("bslu_expected", 32'(exp_bslu_q.size() != 0), 32'd1);
          if (exp_bslu_q.size() != 0) begin
            e = exp_bslu_q.pop_front();
            check("bslu_op", {15'd0, bslu_op, bslu_rs1, bslu_rs2, bslu_rd}, {15'd0, e});
          end
          check("no_req_during_bslu", 32'(mem_req), 32'd0);
        end else begin
          check("bslu_idle_regs", {23'd0, bslu_rs1, bslu_rs2, bslu_rd}, 32'd0);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected per-bit expansion of a command, straight from its semantics.
  task automatic build_model(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                             input logic [15:0] d, input logic [5:0] n);
    logic [15:0] a;
    exp_mem_q.delete();
    exp_bslu_q.delete();
    if (op > 3'd4) return;
    for (int i = 0; i < int'(n); i++) begin
      a = s1 + 16'(i);
      exp_mem_q.push_back({1'b0, a});
      if (op >= 3'd2) begin
        exp_bslu_q.push_back({8'h01, 3'b001, 3'b000, 3'b100});           // mov sa -> pr
        a = s2 + 16'(i);
        exp_mem_q.push_back({1'b0, a});
        case (op)
          3'd2:    exp_bslu_q.push_back({8'h10, 3'b001, 3'b100, 3'b001});
          3'd3:    exp_bslu_q.push_back({8'h20, 3'b001, 3'b100, 3'b001});
          default: exp_bslu_q.push_back({8'h40, 3'b001, 3'b100, 3'b001});
        endcase
      end else if (op == 3'd1) begin
        exp_bslu_q.push_back({8'h08, 3'b001, 3'b000, 3'b001});           // not sa -> sa
      end
      a = d + 16'(i);
      exp_mem_q.push_back({1'b1, a});
    end
  endtask

  // Done cycle (counted from the accept cycle) for deterministic ack modes.
  function automatic int expected_done(input logic [2:0] op, input logic [5:0] n, input int lat);
    int acc_per_bit, step_per_bit;
    acc_per_bit  = (op >= 3'd2) ? 3 : 2;
    step_per_bit = (op >= 3'd2) ? 2 : (op == 3'd1) ? 1 : 0;
    return int'(n) * (acc_per_bit * lat + step_per_bit) + 1;
  endfunction

  // ---------------- driver ----------------
  // abort_at > 0: assert rst at that cycle after accept and check the abort.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                         input logic [15:0] d, input logic [5:0] n, input int mode,
                         input int abort_at);
    int k;
    int w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    ack_mode = mode;
    exp_hold = (mode == 0) ? 1 : (mode == 1) ? 3 : 0;
    build_model(op, s1, s2, d, n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src1  = s1;
    cmd_src2  = s2;
    cmd_dst   = d;
    cmd_nbits = n;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = $urandom_range(0, 7);
    cmd_nbits = $urandom_range(0, 63);
    k = 1;
    if (op > 3'd4) begin
      check("err_pulse", 32'(err), 32'd1);
      check("busy_illegal", 32'(busy), 32'd0);
      check("ready_illegal", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      check("err_one_cycle", 32'(err), 32'd0);
      check("no_done_illegal", 32'(done), 32'd0);
      return;
    end
    if (n != 6'd0) begin
      check("busy_after_accept", 32'(busy), 32'd1);
      check("ready_low_busy", 32'(cmd_ready), 32'd0);
    end
    while (!done && k < 3000 && k != abort_at) begin
      check("no_err_legal", 32'(err), 32'd0);
      @(negedge clk);
      k++;
    end
    if (abort_at != 0 && k == abort_at) begin
      check("abort_in_rd2", {14'd0, mem_req, mem_we, mem_addr}, {14'd0, 2'b10, s2 + 16'd1});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mem_outputs", {14'd0, mem_req, mem_we, mem_addr}, 32'd0);
      check("rst_bslu_outputs", {9'd0, bslu_op, bslu_rs1, bslu_rs2, bslu_rd}, 32'd0);
      check("rst_status", {29'd0, busy, done, err}, 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      exp_mem_q.delete();
      exp_bslu_q.delete();
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
      return;
    end
    check("done_seen", 32'(done), 32'd1);
    if (mode != 2) check("done_cycle", k, expected_done(op, n, (mode == 1) ? 3 : 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("ready_after_done", 32'(cmd_ready), 32'd1);
    check("mem_q_drained", exp_mem_q.size(), 32'd0);
    check("bslu_q_drained", exp_bslu_q.size(), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] rop;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src1  = '0;
    cmd_src2  = '0;
    cmd_dst   = '0;
    cmd_nbits = '0;
    repeat (3) @(negedge clk);
    check("reset_mem", {14'd0, mem_req, mem_we, mem_addr}, 32'd0);
    check("reset_bslu", {9'd0, bslu_op, bslu_rs1, bslu_rs2, bslu_rd}, 32'd0);
    check("reset_status", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(cmd_ready), 32'd1);

    // XOR over two bits, zero-wait memory.
    run_cmd(3'd4, 16'h0010, 16'h0020, 16'h0030, 6'd2, 0, 0);
    // NOT over three bits, ack after the request is held three cycles.
    run_cmd(3'd1, 16'h0100, 16'h0000, 16'h0200, 6'd3, 1, 0);
    // Illegal opcode.
    run_cmd(3'd6, 16'h0001, 16'h0002, 16'h0003, 6'd4, 0, 0);
    // Zero-length COPY.
    run_cmd(3'd0, 16'h0040, 16'h0000, 16'h0050, 6'd0, 0, 0);
    // Address wrap on source and destination.
    run_cmd(3'd0, 16'hFFFE, 16'h0000, 16'hFFFF, 6'd3, 0, 0);
    // AND aborted by reset during the second RD2, then a normal COPY.
    run_cmd(3'd2, 16'h1000, 16'h2000, 16'h3000, 6'd4, 0, 8);
    run_cmd(3'd0, 16'h0A00, 16'h0000, 16'h0B00, 6'd2, 0, 0);
    // OR with the slow responder.
    run_cmd(3'd3, 16'hFFFF, 16'h7FFF, 16'h8000, 6'd2, 1, 0);

    // Random commands and responder behaviour.
    for (int t = 0; t < 30; t++) begin
      rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      run_cmd(rop, 16'($urandom), 16'($urandom), 16'($urandom),
              6'($urandom_range(0, 5)), $urandom_range(0, 2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bslu_seq.md
Name: bslu_seq

Overview:
- Bit-serial micro-op sequencer that drives one bslu_bs2r lane array and its DRAM row port.
- Accepts one vertical-layout bitwise command (COPY/NOT/AND/OR/XOR) over nbits rows.
- Expands it into per-bit row reads, BSLU register ops and row write-backs.
- Sits between the PIM command decoder and the subarray (row port + BSLU op/reg-select bus).

Parameters:
- AW, 16, row address width; operand bit i lives at row base+i, modulo 2^AW
- NBW, 6, width of bit-count field (max 63 bits per command)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  0 COPY, 1 NOT, 2 AND, 3 OR, 4 XOR, 5-7 illegal
- cmd_src1  in  AW  base row of operand A
- cmd_src2  in  AW  base row of operand B (ignored for COPY/NOT)
- cmd_dst  in  AW  base row of destination
- cmd_nbits  in  NBW  number of bit rows
- mem_req  out  1  row access request, held until acked
- mem_we  out  1  0 = row read into sa, 1 = write sa to row
- mem_addr  out  AW  row address, stable while mem_req
- mem_ack  in  1  access completes this cycle (may be same cycle as req)
- bslu_op  out  8  one-hot op to BSLU: b0 mov, b1 set, b2 set-value, b3 not, b4 and, b5 or, b6 xor, b7 sel
- bslu_rs1  out  3  one-hot source 1: 001 sa, 010 cr, 100 pr
- bslu_rs2  out  3  one-hot source 2
- bslu_rd  out  3  one-hot destination
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, command complete
- err  out  1  one-cycle pulse, illegal cmd_op rejected

Behaviour:
- Reset: state IDLE; mem_req=0, mem_we=0, mem_addr=0, bslu_op=0, rs1/rs2/rd=0, busy=0, done=0, err=0, bit counter=0.
- Accept on cmd_valid & cmd_ready; all cmd fields latched; busy=1 from next cycle.
- Illegal op: accepted, err pulses next cycle, no mem/BSLU activity, stays IDLE.
- nbits=0: done pulses next cycle, no mem/BSLU activity.
- States: IDLE, RD1, MV, RD2, ALU, WR, DONE.
- COPY per bit: RD1 -> WR.
- NOT per bit: RD1 -> ALU(not, rs1=sa, rd=sa) -> WR.
- AND/OR/XOR per bit: RD1 -> MV(mov, rs1=sa, rd=pr) -> RD2 -> ALU(op, rs1=sa, rs2=pr, rd=sa) -> WR.
- RD1 reads src1+i, RD2 reads src2+i, WR writes dst+i; addition is modulo 2^AW (wrap, no error).
- RD1/RD2/WR hold mem_req until the cycle mem_ack=1, then advance next cycle; mem_ack while mem_req=0 is ignored.
- MV/ALU last exactly one cycle each; bslu_op is nonzero only in MV/ALU, and rs1/rs2/rd are 0 otherwise.
- After WR ack: if i+1 < nbits, i increments and state goes to RD1; else DONE.
- DONE: done=1 for one cycle, busy drops, then IDLE (cmd_ready=1 the following cycle).
- Zero-wait memory gives 2 cycles/bit for COPY, 3 for NOT, 5 for binary ops.
- rst mid-command aborts immediately: no done; any outstanding req is dropped; the row content is undefined.

Optional Feature:
- BSLU_SEQ_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_stall[31:0].
  - perf_cycles counts busy cycles of the last command.
  - perf_stall counts cycles with mem_req=1 & mem_ack=0.
  - Both clear on command accept and hold after done; 0 on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package bslu_seq_pkg holds:
  - cmd opcode constants
  - BSLU op one-hot constants (OP_MOV, OP_SET, OP_SETV, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SEL)
  - register one-hot constants (REG_SA, REG_CR, REG_PR)
  - state encoding
- One sub-module, bslu_seq_memif: req/ack holding and address-stability logic, reused by all three access states.

Test Plan:
- XOR, src1=0x10, src2=0x20, dst=0x30, nbits=2, mem_ack tied 1:
  - mem_addr sequence 0x10,0x20,0x30,0x11,0x21,0x31
  - bslu_op 0x01 (rd=100) and 0x40 (rs1=001, rs2=100, rd=001) each once per bit
  - done at cycle 11 after accept
- NOT, nbits=3, mem_ack delayed 2 cycles per access -> 3 reads + 3 writes, each mem_req held 3 cycles with stable addr; done once.
- cmd_op=6 -> err pulse 1 cycle, mem_req never asserted, cmd_ready returns high.
- nbits=0 COPY -> done pulse next cycle, no mem_req.
- dst=0xFFFF, src1=0xFFFE, COPY nbits=3 -> write addresses 0xFFFF, 0x0000, 0x0001.
- AND nbits=4, rst asserted during second RD2 -> next cycle all outputs at reset values, no done; a following COPY command executes normally.
